// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and the writeback request type.
//   RF_ADDR_W    - register address width (32 registers)
//   RF_DATA_W    - register data width
//   RF_ZERO_ADDR - hard-wired zero register, writes to it are dropped
//   rf_wr_req_t  - one writeback request {addr, data}
package rf_pkg;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_DATA_W    = 32;
    localparam int RF_ZERO_ADDR = 0;
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a one-hot grant.
//   clk_i, rst_i - clock and synchronous active-high reset
//   en_i         - grants and last_grant updates are allowed only while high
//   req_i[1:0]   - request bits
//   gnt_o[1:0]   - one-hot grant, combinational from req_i and last_grant
module rr_arbiter2 #(
    parameter int FIRST_PRIO = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_grant;
    logic conflict;
    always_comb begin
        conflict = &req_i;
        gnt_o    = en_i ? (conflict ? (last_grant ? 2'b01 : 2'b10) : req_i) : 2'b00;
    end
    // last_grant moves only on a conflict, so a lone requester keeps its turn order
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_grant <= (FIRST_PRIO == 0);
        else if (en_i && conflict)
            last_grant <= gnt_o[1];
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and LSU writeback.
//   clk_i, rst_i            - clock and synchronous active-high reset
//   reqN_valid/addr/data_i  - writeback requests (0 = ALU, 1 = LSU)
//   reqN_ready_o            - request N accepted this cycle
//   rf_we/waddr/wdata_o     - staged write driving the register-file write port
//   fwd_addrN_i             - register-file read addresses
//   fwd_hitN_o, fwd_dataN_o - staged write bypass for each read port
//   conflict_cnt_o          - saturating count of cycles with both requests valid
//   idle_o                  - nothing requested and nothing staged
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int CNT_W      = 16,
    parameter int FIRST_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [ADDR_W-1:0] fwd_addr1_i,
    input  logic [ADDR_W-1:0] fwd_addr2_i,
    output logic              fwd_hit1_o,
    output logic              fwd_hit2_o,
    output logic [DATA_W-1:0] fwd_data1_o,
    output logic [DATA_W-1:0] fwd_data2_o,
    output logic [CNT_W-1:0]  conflict_cnt_o,
    output logic              idle_o
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_ADDR);
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    rr_arbiter2 #(.FIRST_PRIO(FIRST_PRIO)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!rst_i),
        .req_i ({req1_valid_i, req0_valid_i}),
        .gnt_o (gnt)
    );
    always_comb begin
        req0_ready_o = gnt[0];
        req1_ready_o = gnt[1];
        win_addr     = gnt[1] ? req1_addr_i : req0_addr_i;
        win_data     = gnt[1] ? req1_data_i : req0_data_i;
        fwd_hit1_o   = rf_we_o && (rf_waddr_o == fwd_addr1_i) && (fwd_addr1_i != ZERO);
        fwd_hit2_o   = rf_we_o && (rf_waddr_o == fwd_addr2_i) && (fwd_addr2_i != ZERO);
        fwd_data1_o  = fwd_hit1_o ? rf_wdata_o : '0;
        fwd_data2_o  = fwd_hit2_o ? rf_wdata_o : '0;
        idle_o       = !req0_valid_i && !req1_valid_i && !rf_we_o;
    end
    // x0 writes are accepted but never raise the write enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (|gnt) begin
            rf_we_o    <= (win_addr != ZERO);
            rf_waddr_o <= win_addr;
            rf_wdata_o <= win_data;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i)
            conflict_cnt_o <= '0;
        else if (req0_valid_i && req1_valid_i && (conflict_cnt_o != {CNT_W{1'b1}}))
            conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [4:0]  a0 = '0, a1 = '0, fa1 = '0, fa2 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        r0, r1, we, hit1, hit2, idle;
    logic [4:0]  waddr;
    logic [31:0] wdata, fd1, fd2;
    logic [15:0] cnt;
    logic        s_r0, s_r1, s_we, s_hit1, s_hit2, s_idle;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata, s_fd1, s_fd2;
    logic [1:0]  s_cnt;
    logic [31:0] rf [32];
    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    rf_wb_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(r1),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .fwd_addr1_i(fa1), .fwd_addr2_i(fa2),
        .fwd_hit1_o(hit1), .fwd_hit2_o(hit2), .fwd_data1_o(fd1), .fwd_data2_o(fd2),
        .conflict_cnt_o(cnt), .idle_o(idle)
    );

    rf_wb_arbiter #(.CNT_W(2)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(s_r0),
        .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(s_r1),
        .rf_we_o(s_we), .rf_waddr_o(s_waddr), .rf_wdata_o(s_wdata),
        .fwd_addr1_i(fa1), .fwd_addr2_i(fa2),
        .fwd_hit1_o(s_hit1), .fwd_hit2_o(s_hit2), .fwd_data1_o(s_fd1), .fwd_data2_o(s_fd2),
        .conflict_cnt_o(s_cnt), .idle_o(s_idle)
    );

    // register-file model: commits the staged write on the next edge unless the core is in reset
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk_i) if (we && !rst_i) rf[waddr] <= wdata;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; v0 = 1'b1; a0 = 5'd5; d0 = 32'h55; v1 = 1'b1; a1 = 5'd6; d1 = 32'h66;
        #1;
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL reset_ready0 got %b exp 0", r0); end
        tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL reset_ready1 got %b exp 0", r1); end
        tick(); tick();
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", we); end
        tests++; if (waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
        tests++; if (wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", wdata); end
        tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        v0 = 1'b0; v1 = 1'b0; rst_i = 1'b0;
        #1;
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle); end
    endtask

    task automatic test_single_write();
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        tests++; if (r0 !== 1'b1) begin fails++; $display("FAIL single_ready0 got %b exp 1", r0); end
        tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL single_ready1 got %b exp 0", r1); end
        tick();
        v0 = 1'b0;
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL single_we got %b exp 1", we); end
        tests++; if (waddr !== 5'd5) begin fails++; $display("FAIL single_waddr got %0d exp 5", waddr); end
        tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wdata got %h exp deadbeef", wdata); end
        tick();
        tests++; if (rf[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_readback got %h exp deadbeef", rf[5]); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL single_we_drop got %b exp 0", we); end
    endtask

    task automatic test_conflict();
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h11; v1 = 1'b1; a1 = 5'd4; d1 = 32'h22;
        #1;
        tests++; if ({r1, r0} !== 2'b01) begin fails++; $display("FAIL conflict_c0_grant got %b exp 01", {r1, r0}); end
        tick();
        tests++; if ({r1, r0} !== 2'b10) begin fails++; $display("FAIL conflict_c1_grant got %b exp 10", {r1, r0}); end
        tests++; if (waddr !== 5'd3 || wdata !== 32'h11) begin fails++; $display("FAIL conflict_stage0 got %0d/%h exp 3/11", waddr, wdata); end
        tick();
        v0 = 1'b0; v1 = 1'b0;
        tests++; if (waddr !== 5'd4 || wdata !== 32'h22) begin fails++; $display("FAIL conflict_stage1 got %0d/%h exp 4/22", waddr, wdata); end
        tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL conflict_cnt got %0d exp 2", cnt); end
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL conflict_busy got %b exp 0", idle); end
        tick();
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL conflict_idle got %b exp 1", idle); end
        tests++; if (rf[3] !== 32'h11 || rf[4] !== 32'h22) begin fails++; $display("FAIL conflict_rf got %h/%h exp 11/22", rf[3], rf[4]); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        v0 = 1'b1; a0 = 5'd10; d0 = 32'hA0; v1 = 1'b1; a1 = 5'd11; d1 = 32'hB1;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++; if ({r1, r0} !== exp_g) begin fails++; $display("FAIL rr_grant%0d got %b exp %b", i, {r1, r0}, exp_g); end
            tick();
            tests++; if (waddr !== (exp_g[1] ? 5'd11 : 5'd10)) begin fails++; $display("FAIL rr_waddr%0d got %0d", i, waddr); end
        end
        v0 = 1'b0; v1 = 1'b0;
        tests++; if (cnt !== 16'd8) begin fails++; $display("FAIL rr_cnt got %0d exp 8", cnt); end
        tick();
    endtask

    task automatic test_x0_write();
        v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFFFFFF; fa1 = 5'd0;
        #1;
        tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL x0_ready1 got %b exp 1", r1); end
        tick();
        v1 = 1'b0;
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL x0_we got %b exp 0", we); end
        tests++; if (hit1 !== 1'b0 || fd1 !== 32'h0) begin fails++; $display("FAIL x0_fwd got %b/%h exp 0/0", hit1, fd1); end
        tick();
        tests++; if (rf[0] !== 32'h0) begin fails++; $display("FAIL x0_rf got %h exp 0", rf[0]); end
    endtask

    task automatic test_forwarding();
        fa1 = 5'd7; fa2 = 5'd8; v0 = 1'b1; a0 = 5'd7; d0 = 32'hCAFE0001;
        #1;
        tests++; if (hit1 !== 1'b0) begin fails++; $display("FAIL fwd_pending got %b exp 0", hit1); end
        tick();
        v0 = 1'b0;
        #1;
        tests++; if (hit1 !== 1'b1) begin fails++; $display("FAIL fwd_hit1 got %b exp 1", hit1); end
        tests++; if (fd1 !== 32'hCAFE0001) begin fails++; $display("FAIL fwd_data1 got %h exp cafe0001", fd1); end
        tests++; if (hit2 !== 1'b0 || fd2 !== 32'h0) begin fails++; $display("FAIL fwd_port2 got %b/%h exp 0/0", hit2, fd2); end
        fa2 = 5'd7;
        #1;
        tests++; if (hit2 !== 1'b1 || fd2 !== 32'hCAFE0001) begin fails++; $display("FAIL fwd_hit2 got %b/%h exp 1/cafe0001", hit2, fd2); end
        tick();
        tests++; if (hit1 !== 1'b0 || fd1 !== 32'h0) begin fails++; $display("FAIL fwd_after got %b/%h exp 0/0", hit1, fd1); end
        fa1 = 5'd0; fa2 = 5'd0;
    endtask

    task automatic test_reset_midop();
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h1234;
        #1;
        tests++; if (r0 !== 1'b1) begin fails++; $display("FAIL midop_ready0 got %b exp 1", r0); end
        tick();
        v0 = 1'b0; rst_i = 1'b1;
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL midop_staged got %b exp 1", we); end
        tick();
        rst_i = 1'b0;
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL midop_we got %b exp 0", we); end
        tick();
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL midop_we_late got %b exp 0", we); end
        tests++; if (rf[9] !== 32'h0) begin fails++; $display("FAIL midop_rf9 got %h exp 0", rf[9]); end
    endtask

    task automatic test_saturation();
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h1; v1 = 1'b1; a1 = 5'd2; d1 = 32'h2;
        for (int i = 0; i < 5; i++) tick();
        v0 = 1'b0; v1 = 1'b0;
        tests++; if (s_cnt !== 2'd3) begin fails++; $display("FAIL sat_cnt got %0d exp 3", s_cnt); end
        tests++; if (cnt !== 16'd5) begin fails++; $display("FAIL wide_cnt got %0d exp 5", cnt); end
        tick();
        tests++; if (s_cnt !== 2'd3) begin fails++; $display("FAIL sat_hold got %0d exp 3", s_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_conflict();
        test_round_robin();
        test_x0_write();
        test_forwarding();
        test_reset_midop();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
